// File: rtl/data_memory_mapped_io.sv
// Memory-mapped I/O front end: decodes an I/O register window, passes all other accesses to data memory.
// Latency: one cycle for both I/O and memory loads. Backpressure: none, one access is accepted every cycle.
module data_memory_mapped_io #(
   parameter int unsigned           DATA_WIDTH  = 16,
   parameter int unsigned           ADDR_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE     = 16'hFFF0,
   parameter int unsigned           IO_WORDS    = 8,
   parameter int unsigned           SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] read_data,
   input  logic [DATA_WIDTH-1:0] switches,
   output logic [DATA_WIDTH-1:0] leds,
   output logic                  irq,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   localparam int unsigned OFF_W      = (IO_WORDS > 1) ? $clog2(IO_WORDS) : 1;
   localparam int unsigned SUP_CYCLES = SYNC_STAGES + 1;
   localparam int unsigned SUP_W      = $clog2(SUP_CYCLES + 1);

   // One extra address bit so the window end may sit just past the top of the address space.
   localparam logic [ADDR_WIDTH:0] IO_LO = {1'b0, IO_BASE};
   localparam logic [ADDR_WIDTH:0] IO_HI = IO_LO + (ADDR_WIDTH + 1)'(IO_WORDS);

   localparam logic [OFF_W-1:0] OFF_SW     = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_LED    = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_EDGE   = OFF_W'(2);
   localparam logic [OFF_W-1:0] OFF_TIMER  = OFF_W'(3);
   localparam logic [OFF_W-1:0] OFF_CMP    = OFF_W'(4);
   localparam logic [OFF_W-1:0] OFF_STATUS = OFF_W'(5);

   typedef struct packed {
      logic irq_en;
      logic match;
   } status_t;

   // ---------------------------------------------------------------- decode
   logic [ADDR_WIDTH:0] addr_ext;
   logic                io_hit;
   logic [OFF_W-1:0]    offset;
   logic                io_wr;
   logic                wr_led, wr_edge, wr_timer, wr_cmp, wr_status;

   assign addr_ext  = {1'b0, address};
   assign io_hit    = (addr_ext >= IO_LO) && (addr_ext < IO_HI);
   assign offset    = OFF_W'(address - IO_BASE);
   assign io_wr     = write_enable && io_hit;
   assign wr_led    = io_wr && (offset == OFF_LED);
   assign wr_edge   = io_wr && (offset == OFF_EDGE);
   assign wr_timer  = io_wr && (offset == OFF_TIMER);
   assign wr_cmp    = io_wr && (offset == OFF_CMP);
   assign wr_status = io_wr && (offset == OFF_STATUS);

   assign mem_address      = address;
   assign mem_write_data   = write_data;
   assign mem_write_enable = write_enable && !io_hit;

   // ---------------------------------------------------------------- switch synchroniser
   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [DATA_WIDTH-1:0] sw_s;
   logic [DATA_WIDTH-1:0] sw_prev_q;

   assign sw_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         sw_prev_q <= '0;
      end else begin
         sync_q[0] <= switches;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         sw_prev_q <= sw_s;
      end
   end

   // Hold EDGE while the chain refills after reset, so levels already high do not look like edges.
   logic [SUP_W-1:0] sup_cnt_q;
   logic             edge_en;

   assign edge_en = (sup_cnt_q == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         sup_cnt_q <= SUP_W'(SUP_CYCLES);
      end else if (!edge_en) begin
         sup_cnt_q <= sup_cnt_q - SUP_W'(1);
      end
   end

   // ---------------------------------------------------------------- registers
   logic [DATA_WIDTH-1:0] leds_q;
   logic [DATA_WIDTH-1:0] edge_q, edge_d, edge_clr, edge_rise;
   logic [DATA_WIDTH-1:0] timer_q, timer_d;
   logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
   status_t               status_q, status_d;

   assign edge_rise = sw_s & ~sw_prev_q;
   assign edge_clr  = wr_edge ? write_data : '0;
   assign edge_d    = (edge_q & ~edge_clr) | edge_rise;

   assign timer_d = wr_timer ? write_data : timer_q + DATA_WIDTH'(1);
   assign cmp_d   = wr_cmp ? write_data : cmp_q;

   // Match compares the post-update timer and compare values; a new match beats a same-cycle clear.
   always_comb begin
      status_d = status_q;
      if (wr_status) begin
         status_d.irq_en = write_data[1];
         if (write_data[0]) begin
            status_d.match = 1'b0;
         end
      end
      if (timer_d == cmp_d) begin
         status_d.match = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         leds_q   <= '0;
         edge_q   <= '0;
         timer_q  <= '0;
         cmp_q    <= '0;
         status_q <= '0;
      end else begin
         if (wr_led) begin
            leds_q <= write_data;
         end
         if (edge_en) begin
            edge_q <= edge_d;
         end
         timer_q  <= timer_d;
         cmp_q    <= cmp_d;
         status_q <= status_d;
      end
   end

   assign leds = leds_q;
   assign irq  = status_q.match && status_q.irq_en;

   // ---------------------------------------------------------------- read path
   logic [DATA_WIDTH-1:0] io_rdata_d, io_rdata_q;
   logic                  io_sel_q;

   always_comb begin
      io_rdata_d = '0;
      case (offset)
         OFF_SW:     io_rdata_d = sw_s;
         OFF_LED:    io_rdata_d = leds_q;
         OFF_EDGE:   io_rdata_d = edge_q;
         OFF_TIMER:  io_rdata_d = timer_q;
         OFF_CMP:    io_rdata_d = cmp_q;
         OFF_STATUS: begin
            io_rdata_d[1] = status_q.irq_en;
            io_rdata_d[0] = status_q.match;
         end
         default:    io_rdata_d = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         io_sel_q   <= 1'b0;
         io_rdata_q <= '0;
      end else begin
         io_sel_q   <= io_hit;
         io_rdata_q <= io_rdata_d;
      end
   end

   // Memory supplies its own registered data, so only a mux is needed to match I/O latency.
   assign read_data = io_sel_q ? io_rdata_q : mem_read_data;

endmodule

// File: tb/tb_data_memory_mapped_io.sv
// Bench for data_memory_mapped_io: directed scenarios plus random traffic against a register-level model.
module tb_data_memory_mapped_io;
   localparam int          S    = 2;
   localparam logic [15:0] BASE = 16'hFFF0;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] address, write_data, read_data, switches, leds;
   logic [15:0] mem_address, mem_write_data, mem_read_data;
   logic        write_enable, irq, mem_write_enable;

   always #5 clock = ~clock;

   data_memory_mapped_io #(
      .DATA_WIDTH(16), .ADDR_WIDTH(16), .IO_BASE(BASE), .IO_WORDS(8), .SYNC_STAGES(S)
   ) dut (
      .clock(clock), .reset(reset), .address(address), .write_data(write_data),
      .write_enable(write_enable), .read_data(read_data), .switches(switches), .leds(leds),
      .irq(irq), .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
   );

   // External synchronous data memory
   bit [15:0] mem [65536];
   always @(posedge clock) begin
      if (mem_write_enable) mem[mem_address] <= mem_write_data;
      mem_read_data <= mem[mem_address];
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: register contents as seen by software
   logic [15:0] m_leds, m_edge, m_timer, m_cmp;
   logic        m_match, m_irqen;
   logic [15:0] hist [0:S];   // hist[0] = most recent switch sample
   int          rel;          // clock edges since reset release
   logic [15:0] sw;
   logic [15:0] exp_rd, obs_maddr;
   logic        exp_mwe, obs_mwe;

   function automatic logic [15:0] m_reg(input int off);
      case (off)
         0: return hist[S-1];
         1: return m_leds;
         2: return m_edge;
         3: return m_timer;
         4: return m_cmp;
         5: return {14'd0, m_irqen, m_match};
         default: return 16'd0;
      endcase
   endfunction

   task automatic cycle(input logic [15:0] a, input logic [15:0] wd, input logic we, input logic rst);
      int ai, off;
      bit hit, w;
      logic [15:0] clr, sws, swp;
      address = a; write_data = wd; write_enable = we; reset = rst; switches = sw;
      #2;
      obs_mwe = mem_write_enable; obs_maddr = mem_address;
      ai  = int'(a);
      off = ai - int'(BASE);
      hit = (ai >= int'(BASE)) && (ai < int'(BASE) + 8);
      w   = we && hit;
      exp_mwe = we && !hit;
      exp_rd  = (hit && !rst) ? m_reg(off) : mem[a];
      @(posedge clock); #1;
      if (rst) begin
         m_leds = 0; m_edge = 0; m_timer = 0; m_cmp = 0; m_match = 0; m_irqen = 0; rel = 0;
         for (int i = 0; i <= S; i++) hist[i] = 0;
      end else begin
         sws = hist[S-1]; swp = hist[S];
         if (rel >= S + 1) begin
            clr = (w && off == 2) ? wd : 16'd0;
            m_edge = (m_edge & ~clr) | (sws & ~swp);
         end else begin
            rel++;
         end
         m_timer = (w && off == 3) ? wd : m_timer + 16'd1;
         if (w && off == 1) m_leds = wd;
         if (w && off == 4) m_cmp = wd;
         if (w && off == 5) begin
            m_irqen = wd[1];
            if (wd[0]) m_match = 0;
         end
         if (m_timer == m_cmp) m_match = 1;
         for (int i = S; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = sw;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(16'h0020, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset;
      sw = 16'h0;
      cycle(16'h0010, 16'h0, 1'b0, 1'b1);
      cycle(BASE + 16'd1, 16'h0, 1'b0, 1'b1);
      n_cmp++; if (leds !== 16'h0) begin n_bad++; $display("FAIL reset_leds: got %h want 0000", leds); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
      n_cmp++; if (read_data !== exp_rd) begin n_bad++; $display("FAIL reset_read_mem: got %h want %h", read_data, exp_rd); end
      cycle(BASE + 16'd5, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0000", read_data); end
   endtask

   task automatic test_led;
      cycle(BASE + 16'd1, 16'hA5A5, 1'b1, 1'b0);
      n_cmp++; if (obs_mwe !== 1'b0) begin n_bad++; $display("FAIL led_mwe: got %b want 0", obs_mwe); end
      n_cmp++; if (leds !== 16'hA5A5) begin n_bad++; $display("FAIL led_value: got %h want a5a5", leds); end
      cycle(BASE + 16'd1, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'hA5A5) begin n_bad++; $display("FAIL led_read: got %h want a5a5", read_data); end
   endtask

   task automatic test_mem;
      cycle(16'h0010, 16'h1234, 1'b1, 1'b0);
      n_cmp++; if (obs_mwe !== 1'b1) begin n_bad++; $display("FAIL mem_mwe: got %b want 1", obs_mwe); end
      n_cmp++; if (obs_maddr !== 16'h0010) begin n_bad++; $display("FAIL mem_addr: got %h want 0010", obs_maddr); end
      cycle(16'h0010, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h1234) begin n_bad++; $display("FAIL mem_read: got %h want 1234", read_data); end
   endtask

   task automatic test_switches;
      sw = 16'h0005;
      idle(S + 2);
      cycle(BASE, 16'hFFFF, 1'b1, 1'b0);
      n_cmp++; if (read_data !== 16'h0005) begin n_bad++; $display("FAIL sw_read: got %h want 0005", read_data); end
      cycle(BASE + 16'd2, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0005) begin n_bad++; $display("FAIL edge_capture: got %h want 0005", read_data); end
      cycle(BASE + 16'd2, 16'h0001, 1'b1, 1'b0);
      cycle(BASE + 16'd2, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0004) begin n_bad++; $display("FAIL edge_w1c: got %h want 0004", read_data); end
      cycle(BASE + 16'd2, 16'h0004, 1'b1, 1'b0);
      sw = 16'h0001;
      idle(S + 2);
      sw = 16'h0005;
      idle(S);
      cycle(BASE + 16'd2, 16'h0004, 1'b1, 1'b0);   // clear lands on the same edge as the new rise
      cycle(BASE + 16'd2, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0004) begin n_bad++; $display("FAIL edge_set_wins: got %h want 0004", read_data); end
   endtask

   task automatic test_timer_match;
      cycle(BASE + 16'd4, 16'd10, 1'b1, 1'b0);
      cycle(BASE + 16'd5, 16'h0001, 1'b1, 1'b0);
      cycle(BASE + 16'd5, 16'h0002, 1'b1, 1'b0);
      cycle(BASE + 16'd3, 16'd5, 1'b1, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         idle(1);
         n_cmp++;
         if (irq !== (k == 5)) begin n_bad++; $display("FAIL match_irq_k%0d: got %b want %b", k, irq, (k == 5)); end
      end
      cycle(BASE + 16'd5, 16'h0003, 1'b1, 1'b0);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL match_clear_irq: got %b want 0", irq); end
      cycle(BASE + 16'd5, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0002) begin n_bad++; $display("FAIL status_read: got %h want 0002", read_data); end
   endtask

   task automatic test_wrap;
      logic [15:0] want [3];
      want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
      cycle(BASE + 16'd3, 16'hFFFE, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle(BASE + 16'd3, 16'h0, 1'b0, 1'b0);
         n_cmp++;
         if (read_data !== want[k]) begin n_bad++; $display("FAIL timer_wrap_%0d: got %h want %h", k, read_data, want[k]); end
      end
   endtask

   task automatic test_reset_mid;
      cycle(BASE + 16'd1, 16'hFFFF, 1'b1, 1'b1);
      n_cmp++; if (leds !== 16'h0) begin n_bad++; $display("FAIL midreset_leds: got %h want 0000", leds); end
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
      n_cmp++; if (read_data !== exp_rd) begin n_bad++; $display("FAIL midreset_read: got %h want %h", read_data, exp_rd); end
      cycle(BASE + 16'd4, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0) begin n_bad++; $display("FAIL midreset_cmp: got %h want 0000", read_data); end
      cycle(BASE + 16'd5, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0) begin n_bad++; $display("FAIL midreset_status: got %h want 0000", read_data); end
      idle(S + 3);
      cycle(BASE + 16'd2, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0) begin n_bad++; $display("FAIL edge_suppress: got %h want 0000", read_data); end
      cycle(BASE + 16'd6, 16'hBEEF, 1'b1, 1'b0);
      n_cmp++; if (obs_mwe !== 1'b0) begin n_bad++; $display("FAIL rsvd_mwe: got %b want 0", obs_mwe); end
      cycle(BASE + 16'd6, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0) begin n_bad++; $display("FAIL rsvd6_read: got %h want 0000", read_data); end
      cycle(BASE + 16'd7, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0) begin n_bad++; $display("FAIL rsvd7_read: got %h want 0000", read_data); end
   endtask

   task automatic test_boundaries;
      cycle(BASE - 16'd1, 16'h5A5A, 1'b1, 1'b0);
      n_cmp++; if (obs_mwe !== 1'b1) begin n_bad++; $display("FAIL below_mwe: got %b want 1", obs_mwe); end
      cycle(16'h0000, 16'hC3C3, 1'b1, 1'b0);
      n_cmp++; if (obs_mwe !== 1'b1) begin n_bad++; $display("FAIL wrap0_mwe: got %b want 1", obs_mwe); end
      cycle(BASE - 16'd1, 16'h0, 1'b0, 1'b0);
      cycle(16'h0000, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'hC3C3) begin n_bad++; $display("FAIL wrap0_read: got %h want c3c3", read_data); end
      cycle(16'h0020, 16'h0, 1'b0, 1'b0);
      n_cmp++; if (read_data !== 16'h0000) begin n_bad++; $display("FAIL mem_idle_read: got %h want 0000", read_data); end
   endtask

   task automatic test_back_to_back_random;
      logic [15:0] a;
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: a = BASE + 16'($urandom_range(0, 7));
            1: a = BASE + 16'($urandom_range(0, 9)) - 16'd1;
            2: a = 16'($urandom_range(0, 31));
            default: a = 16'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
         cycle(a, 16'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0));
         n_cmp += 4;
         if (read_data !== exp_rd) begin n_bad++; errs++; if (errs < 10) $display("FAIL rand_read@%0d: got %h want %h", i, read_data, exp_rd); end
         if (leds !== m_leds) begin n_bad++; errs++; if (errs < 10) $display("FAIL rand_leds@%0d: got %h want %h", i, leds, m_leds); end
         if (irq !== (m_match & m_irqen)) begin n_bad++; errs++; if (errs < 10) $display("FAIL rand_irq@%0d: got %b want %b", i, irq, m_match & m_irqen); end
         if (obs_mwe !== exp_mwe) begin n_bad++; errs++; if (errs < 10) $display("FAIL rand_mwe@%0d: got %b want %b", i, obs_mwe, exp_mwe); end
      end
   endtask

   initial begin
      reset = 1'b1; address = '0; write_data = '0; write_enable = 1'b0; switches = '0; sw = '0;
      test_reset;
      test_led;
      test_mem;
      test_switches;
      test_timer_match;
      test_wrap;
      test_reset_mid;
      test_boundaries;
      test_back_to_back_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
